// File: rtl/rc_lvds_frontend.sv
// ============================================================================
// Module   : rc_lvds_frontend
// Purpose  : First-order RC-equivalent IIR filter of a PWM bit stream followed
//            by a registered LVDS-style comparator against an analog input.
//            Define RC_LVDS_HYST_EN to enable the HYST comparator window.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rc_lvds_frontend #(
    parameter int W     = 16,
    parameter int ALPHA = 459,
    parameter int HYST  = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         pwm_i,
    input  logic [W-1:0] ana_i,
    output logic [W-1:0] filt_o,
    output logic         lvds_o
);

    localparam logic [W-1:0]       c_FS    = {W{1'b1}};
    localparam logic signed [16:0] c_ALPHA = 17'(ALPHA);
`ifdef RC_LVDS_HYST_EN
    localparam bit                 c_HYST_ON = 1'b1;
`else
    localparam bit                 c_HYST_ON = 1'b0;
`endif
    localparam logic [W:0]         c_HYST  = c_HYST_ON ? (W+1)'(HYST) : '0;

    logic signed [W:0]    w_diff;
    logic signed [W+16:0] w_prod;
    logic signed [W:0]    w_step;
    logic        [W+1:0]  w_sum;
    logic        [W-1:0]  w_filt_next;
    logic        [W:0]    w_filt_ext;
    logic        [W:0]    w_ana_ext;
    logic                 w_lvds_next;

    always_comb begin
        w_diff = $signed({1'b0, (pwm_i ? c_FS : {W{1'b0}})}) - $signed({1'b0, filt_o});
        w_prod = w_diff * c_ALPHA;
        w_step = (W+1)'(w_prod >>> 16);
        // Tiny positive steps floor to zero; nudge by one so the state reaches FS.
        if ((w_step == '0) && (w_diff > 0)) begin
            w_step = (W+1)'(1);
        end
        w_sum = {2'b00, filt_o} + {w_step[W], w_step};
        if (w_sum[W+1]) begin
            w_filt_next = '0;
        end else if (w_sum[W]) begin
            w_filt_next = c_FS;
        end else begin
            w_filt_next = w_sum[W-1:0];
        end
    end

    // With a zero window the hold branch only covers equality, which reads as 0.
    always_comb begin
        w_filt_ext = {1'b0, filt_o};
        w_ana_ext  = {1'b0, ana_i};
        if (w_filt_ext > (w_ana_ext + c_HYST)) begin
            w_lvds_next = 1'b1;
        end else if ((w_filt_ext + c_HYST) < w_ana_ext) begin
            w_lvds_next = 1'b0;
        end else begin
            w_lvds_next = c_HYST_ON ? lvds_o : 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            filt_o <= '0;
            lvds_o <= 1'b0;
        end else begin
            if (en_i) begin
                filt_o <= w_filt_next;
            end
            lvds_o <= w_lvds_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rc_lvds_frontend.sv
// ============================================================================
// Module   : tb_rc_lvds_frontend
// Purpose  : Self-checking bench for rc_lvds_frontend with an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rc_lvds_frontend;

    localparam int    W     = 16;
    localparam int    ALPHA = 459;
    localparam int    HYST  = 64;
    localparam longint FS   = 65535;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          en_i;
    logic          pwm_i;
    logic [W-1:0]  ana_i;
    logic [W-1:0]  filt_o;
    logic          lvds_o;

    int     n_checks = 0;
    int     n_errors = 0;
    longint m_filt   = 0;
    bit     m_lvds   = 1'b0;

    rc_lvds_frontend #(.W(W), .ALPHA(ALPHA), .HYST(HYST)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (en_i),
        .pwm_i  (pwm_i),
        .ana_i  (ana_i),
        .filt_o (filt_o),
        .lvds_o (lvds_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Filter update written as plain integer arithmetic with floor division.
    function automatic longint model_step(input longint f, input bit p);
        longint d, num, s, n;
        d   = (p ? FS : 0) - f;
        num = d * ALPHA;
        s   = (num >= 0) ? (num / 65536) : ((num - 65535) / 65536);
        if (s == 0 && d > 0) s = 1;
        n = f + s;
        if (n < 0) n = 0;
        if (n > FS) n = FS;
        return n;
    endfunction

    function automatic bit model_cmp(input longint f, input longint a, input bit prev);
`ifdef RC_LVDS_HYST_EN
        if (f > a + HYST) return 1'b1;
        if (f + HYST < a) return 1'b0;
        return prev;
`else
        return (f > a);
`endif
    endfunction

    // One clock edge: advance the model with the inputs presented, then compare.
    task automatic tick();
        bit     nl;
        longint nf;
        nl = model_cmp(m_filt, longint'(ana_i), m_lvds);
        nf = en_i ? model_step(m_filt, pwm_i) : m_filt;
        @(posedge clk_i);
        if (rst_i) begin
            m_filt = 0;
            m_lvds = 1'b0;
        end else begin
            m_filt = nf;
            m_lvds = nl;
        end
        #1;
        check("filt", longint'(filt_o), m_filt);
        check("lvds", longint'(lvds_o), longint'(m_lvds));
    endtask

    initial begin
        longint prev, saved;
        bit     done, in_range;

        rst_i = 1'b1; en_i = 1'b1; pwm_i = 1'b1; ana_i = W'($urandom);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_filt", longint'(filt_o), 0);
            check("rst_lvds", longint'(lvds_o), 0);
        end

        // Step up from reset against a mid-scale threshold.
        rst_i = 1'b0; ana_i = 16'd32768;
        tick();
        check("first_up", longint'(filt_o), 458);
        prev = filt_o; done = 1'b0;
        for (int i = 0; i < 4000 && !done; i++) begin
            tick();
            check("mono_up", longint'(filt_o >= prev), 1);
            prev = filt_o;
            if (filt_o == 16'hFFFF) done = 1'b1;
        end
        check("reach_fs", longint'(filt_o), FS);
        repeat (10) tick();
        check("hold_fs", longint'(filt_o), FS);
        check("lvds_high_at_fs", longint'(lvds_o), 1);

        // Step down to ground.
        pwm_i = 1'b0;
        tick();
        check("first_down", longint'(filt_o), 65076);
        prev = filt_o; done = 1'b0;
        for (int i = 0; i < 4000 && !done; i++) begin
            tick();
            check("mono_down", longint'(filt_o <= prev), 1);
            prev = filt_o;
            if (filt_o == '0) done = 1'b1;
        end
        check("reach_zero", longint'(filt_o), 0);

        // 50% duty, period 64.
        for (int c = 0; c < 5000; c++) begin
            pwm_i = ((c % 64) < 32);
            ana_i = W'($urandom_range(0, 65535));
            tick();
        end
        in_range = 1'b1;
        for (int c = 0; c < 128; c++) begin
            pwm_i = ((c % 64) < 32);
            tick();
            if (filt_o < 16'd24768 || filt_o > 16'd40768) in_range = 1'b0;
        end
        check("duty_window", longint'(in_range), 1);

        // Enable freeze and mid-ramp reset.
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        pwm_i = 1'b1; en_i = 1'b1;
        repeat (200) tick();
        saved = filt_o;
        en_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("frozen", longint'(filt_o), saved);
        end
        en_i = 1'b1;
        tick();
        check("resume", longint'(filt_o), model_step(saved, 1'b1));
        repeat (50) tick();
        rst_i = 1'b1;
        tick();
        check("mid_rst", longint'(filt_o), 0);
        rst_i = 1'b0;

        // Random traffic; ana_i often parked near the filter to probe the threshold.
        for (int i = 0; i < 3000; i++) begin
            longint a;
            rst_i = ($urandom_range(0, 299) == 0);
            en_i  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) pwm_i = ~pwm_i;
            if ($urandom_range(0, 1) == 0) begin
                a = m_filt + longint'($urandom_range(0, 300)) - 150;
                if (a < 0) a = 0;
                if (a > FS) a = FS;
                ana_i = W'(a);
            end else begin
                ana_i = W'($urandom_range(0, 65535));
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rc_lvds_frontend.md
# rc_lvds_frontend

Synthesizable digital model of the PWM-DAC analog front end used by the ramp/SAR converter. It low-pass filters the 1-bit PWM stream with a first-order RC-equivalent IIR and compares the filtered level against a digitised analog input with an LVDS-style comparator. The 1-bit comparator decision feeds back into the converter control logic.

## Interface
- `W`, 16: width of the filter state, analog input and filtered output (unsigned, full scale FS = 2^W-1 = VDD).
- `ALPHA`, 459: filter coefficient in Q0.16 (459/65536 ≈ 0.007); legal range 1..65535.
- `HYST`, 64: comparator hysteresis in LSBs; used only when `RC_LVDS_HYST_EN` is defined.

- `clk_i`, in, 1: single clock; every register updates on its rising edge.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `en_i`, in, 1: filter update enable; when 0 the filter state holds.
- `pwm_i`, in, 1: PWM bit; 1 = VDD (FS), 0 = ground (0).
- `ana_i`, in, W: analog input code (the comparator's `ln` leg).
- `filt_o`, out, W: registered filter state (the comparator's `lp` leg).
- `lvds_o`, out, 1: registered comparator decision, 1 when `filt_o` > `ana_i`.

## Operation
- Target: tgt = pwm_i ? FS : 0.
- Difference: d = tgt − filt_o, signed, W+1 bits.
- Product: p = d × ALPHA, signed, W+17 bits, no overflow possible.
- Step: s = p >>> 16 (arithmetic shift, i.e. floor).
  - If s == 0 and d > 0, force s = 1 so the filter converges exactly to FS.
  - Negative d already floors to at most −1, so the filter converges exactly to 0.
- Update: filt_o ← filt_o + s, clamped to [0, FS]. The clamp is defensive; with ALPHA < 1 the state cannot overshoot.
- en_i = 0: filt_o holds its value; the comparator keeps evaluating.
- Comparator without hysteresis: lvds_o ← (filt_o > ana_i). Equal values give 0.
- Comparator with hysteresis:
  - lvds_o rises only when filt_o > ana_i + HYST.
  - lvds_o falls only when filt_o + HYST < ana_i.
  - Otherwise lvds_o holds.
  - Sums are computed at W+1 bits, so there is no wrap-around.
- Reset: filt_o = 0, lvds_o = 0. Reset overrides en_i and may be asserted mid-operation; the state returns to 0 on that edge.

## Timing
- filt_o latency: one cycle from pwm_i to the filt_o update.
- lvds_o latency: registered from the current filt_o and ana_i.
  - An ana_i change is reflected on lvds_o at the next edge.
  - A pwm_i change reaches lvds_o no earlier than 2 edges later.
- No handshake; all inputs are sampled every cycle. ana_i must be stable at the clock edge (synchronous to clk_i).
- Throughput: one filter step per enabled cycle. The time constant is ≈ 65536/ALPHA cycles (≈143 cycles at the default).

## Configuration
- `RC_LVDS_HYST_EN` defined: comparator uses the HYST hysteresis window described in Operation.
- `RC_LVDS_HYST_EN` undefined: the HYST parameter is ignored and the comparator is a plain strict greater-than.

## Test plan
- Reset check: assert rst_i with pwm_i = 1, en_i = 1 -> filt_o = 0 and lvds_o = 0 on every cycle while reset is held.
- Step up, defaults: pwm_i = 1, en_i = 1 from reset.
  - First edge -> filt_o = 458 (floor(65535·459/65536)).
  - Then monotonically rising, reaching exactly 65535 and staying there.
- Step down: from FS, pwm_i = 0 -> first step filt_o = 65535 − 459 = 65076; decays monotonically to exactly 0.
- 50% duty: PWM with period 64 cycles, after 5000 cycles -> filt_o stays within 32768 ± 8000.
- Comparator threshold, ana_i = 32768, filt_o rising through it:
  - Without the macro: lvds_o goes 1 the cycle after filt_o first exceeds 32768, and is 0 at equality.
  - With the macro: lvds_o goes 1 only after filt_o > 32832, and returns to 0 only after filt_o < 32704.
- Enable and mid-run reset:
  - en_i = 0 mid-ramp -> filt_o frozen for 20 cycles, resumes from the same value.
  - rst_i pulse mid-ramp -> filt_o = 0 the next cycle.
